// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - line request to single-word memory beat sequencer
// Splits one L2 line read/write into BEATS word accesses with per-beat timeout.
module mem_req_ctrl #(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 32,
  parameter int BEATS   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_rw,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W*BEATS-1:0]  req_wdata,
  output logic                     resp_valid,
  output logic                     resp_err,
  output logic [DATA_W*BEATS-1:0]  resp_rdata,
  output logic                     mem_req,
  output logic                     mem_rw,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wd,
  input  logic [DATA_W-1:0]        mem_rd,
  input  logic                     mem_complete
);

  localparam int BW = $clog2(BEATS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = DATA_W * BEATS;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
  localparam logic [TW-1:0]     LAST_TICK = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BEATS - 1);

  logic [1:0]        state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LW-1:0]     wdata_q, wdata_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [LW-1:0]     rdata_q, rdata_d;
  logic [BW-1:0]     beat_nx;

  assign beat_nx = beat_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    beat_d       = beat_q;
    tcnt_d       = tcnt_q;
    mem_req_d    = mem_req_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wd_d     = mem_wd_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    rdata_d      = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d    = S_ACCESS;
          rw_d       = req_rw;
          base_d     = req_addr & LINE_MASK;
          wdata_d    = req_wdata;
          beat_d     = '0;
          tcnt_d     = '0;
          mem_req_d  = 1'b1;
          mem_rw_d   = req_rw;
          mem_addr_d = req_addr & LINE_MASK;
          mem_wd_d   = req_wdata[DATA_W-1:0];
        end
      end
      S_ACCESS: begin
        // Completion is checked first so a pulse in the final allowed cycle still succeeds.
        if (mem_complete) begin
          tcnt_d    = '0;
          mem_req_d = 1'b0;
          if (!rw_q) rdata_d[DATA_W*int'(beat_q) +: DATA_W] = mem_rd;
          if (beat_q == LAST_BEAT) begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end else if (tcnt_q == LAST_TICK) begin
          tcnt_d       = '0;
          mem_req_d    = 1'b0;
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_GAP: begin
        beat_d     = beat_nx;
        state_d    = S_ACCESS;
        mem_req_d  = 1'b1;
        mem_addr_d = base_q | {{(ADDR_W-BW){1'b0}}, beat_nx};
        mem_wd_d   = wdata_q[DATA_W*int'(beat_nx) +: DATA_W];
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rw_q         <= 1'b0;
      base_q       <= '0;
      wdata_q      <= '0;
      beat_q       <= '0;
      tcnt_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      rw_q         <= rw_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      beat_q       <= beat_d;
      tcnt_q       <= tcnt_d;
      mem_req_q    <= mem_req_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wd_q     <= mem_wd_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_rw     = mem_rw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - scoreboard bench for mem_req_ctrl
// Responder model on negedge; expected beats and responses queued at stimulus time.
module tb_mem_req_ctrl;

  localparam int TOUT = 64;

  typedef struct {
    logic [25:0] addr;
    logic        rw;
    logic [31:0] wd;
  } beat_t;

  typedef struct {
    logic         err;
    logic [127:0] rdata;
    int           lat;
  } resp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_rw = 1'b0;
  logic [25:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         resp_valid;
  logic         resp_err;
  logic [127:0] resp_rdata;
  logic         mem_req;
  logic         mem_rw;
  logic [25:0]  mem_addr;
  logic [31:0]  mem_wd;
  logic [31:0]  mem_rd = '0;
  logic         mem_complete = 1'b0;

  mem_req_ctrl #(.ADDR_W(26), .DATA_W(32), .BEATS(4), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .mem_complete(mem_complete)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int n_resp   = 0;
  int run      = 0;
  int last_run = 0;
  int lat_cfg  = 1;
  logic [31:0] rd_base = '0;
  logic        spur = 1'b0;
  int rcnt = 0;
  int acc_h  [0:63];
  int resp_h [0:63];
  logic [127:0] model_rdata = '0;

  beat_t beat_q[$];
  resp_t exp_q[$];
  int    acc_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: completes on the lat_cfg-th cycle of mem_req (0 = never).
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      rcnt = 0;
      mem_complete = 1'b0;
    end else if (mem_req) begin
      rcnt++;
      if (rcnt == lat_cfg) begin
        mem_complete = 1'b1;
        mem_rd = rd_base + {30'd0, mem_addr[1:0]};
        if (beat_q.size() == 0) begin
          chk("unexp_beat", 1'b1, 1'b0);
        end else begin
          b = beat_q.pop_front();
          chk("beat_addr", mem_addr, b.addr);
          chk("beat_rw", mem_rw, b.rw);
          if (b.rw) chk("beat_wd", mem_wd, b.wd);
        end
      end else begin
        mem_complete = 1'b0;
        mem_rd = 32'h0;
      end
    end else begin
      rcnt = 0;
      mem_complete = spur;
      mem_rd = spur ? 32'hDEADBEEF : 32'h0;
    end
  end

  always @(negedge clk) begin
    resp_t e;
    int a;
    if (!rst) begin
      if (req_valid && req_ready) begin
        acc_q.push_back(cyc + 1);
        acc_h[n_acc % 64] = cyc + 1;
        n_acc++;
      end
      if (mem_req) run++;
      else begin
        if (run != 0) last_run = run;
        run = 0;
      end
      if (resp_valid) begin
        resp_h[n_resp % 64] = cyc + 1;
        n_resp++;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("unexp_resp", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("resp_err", resp_err, e.err);
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_lat", 128'(cyc + 1 - a), 128'(e.lat));
        end
      end
    end
  end

  task automatic expect_line(input logic rw, input logic [25:0] addr, input logic [127:0] wd,
                             input int lat, input logic [31:0] rbase, input logic to);
    beat_t b;
    resp_t r;
    logic [25:0] a;
    a = addr & ~26'h3;
    if (!to) begin
      for (int i = 0; i < 4; i++) begin
        b.addr = a | 26'(i);
        b.rw   = rw;
        b.wd   = wd[32*i +: 32];
        beat_q.push_back(b);
        if (!rw) model_rdata[32*i +: 32] = rbase + 32'(i);
      end
      r.err = 1'b0;
      r.lat = 4 * lat + 3 + 1;
    end else begin
      r.err = 1'b1;
      r.lat = TOUT + 1;
    end
    r.rdata = model_rdata;
    exp_q.push_back(r);
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 600 && n_acc < target; i++) begin
      @(posedge clk);
      #2;
    end
    chk("acc_wait", 1'(n_acc >= target), 1'b1);
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 600 && n_resp < target; i++) begin
      @(posedge clk);
      #2;
    end
    chk("resp_wait", 1'(n_resp >= target), 1'b1);
  endtask

  task automatic do_line(input logic rw, input logic [25:0] addr, input logic [127:0] wd,
                         input int lat, input logic [31:0] rbase, input logic to);
    int a0, r0;
    a0 = n_acc;
    r0 = n_resp;
    lat_cfg = to ? 0 : lat;
    rd_base = rbase;
    expect_line(rw, addr, wd, lat, rbase, to);
    @(posedge clk);
    #2;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wd;
    wait_acc(a0 + 1);
    req_valid = 1'b0;
    req_addr  = 26'h3FFFFFF;
    req_wdata = {4{32'hBAD0BAD0}};
    wait_resp(r0 + 1);
  endtask

  initial begin
    int a0, r0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_rw", mem_rw, 1'b0);
    chk("rst_mem_addr", mem_addr, 26'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_rdata", resp_rdata, 128'h0);

    // Asynchronous reset in the middle of a beat.
    lat_cfg = 0;
    a0 = n_acc;
    @(posedge clk);
    #2;
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = 26'h8;
    wait_acc(a0 + 1);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("t1_mem_req_on", mem_req, 1'b1);
    r0 = n_resp;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t1_mem_req_async", mem_req, 1'b0);
    chk("t1_resp_valid_async", resp_valid, 1'b0);
    #1 rst = 1'b0;
    acc_q.delete();
    beat_q.delete();
    @(posedge clk);
    #2;
    chk("t1_ready", req_ready, 1'b1);
    repeat (10) @(posedge clk);
    #2;
    chk("t1_no_resp", 32'(n_resp), 32'(r0));
    chk("t1_rdata", resp_rdata, 128'h0);

    // Read with unaligned address, L=3.
    do_line(1'b0, 26'h0000013, 128'h0, 3, 32'hA0, 1'b0);
    chk("t2_rdata_const", resp_rdata, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    // Write, L=1; read data must survive.
    do_line(1'b1, 26'h0000020, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
            1, 32'h0, 1'b0);

    // Responder never completes.
    do_line(1'b0, 26'h0000100, 128'h0, 0, 32'hC0, 1'b1);
    chk("t4_run", 32'(last_run), 32'(TOUT));
    chk("t4_ready", req_ready, 1'b1);

    // Spurious completes while idle, then a read with spurious completes in the gaps.
    spur = 1'b1;
    r0 = n_resp;
    repeat (5) @(posedge clk);
    #2;
    chk("t5_idle_ready", req_ready, 1'b1);
    chk("t5_idle_mem_req", mem_req, 1'b0);
    chk("t5_idle_no_resp", 32'(n_resp), 32'(r0));
    do_line(1'b0, 26'h0000204, 128'h0, 2, 32'hD0, 1'b0);
    spur = 1'b0;
    do_line(1'b0, 26'h0000300, 128'h0, TOUT, 32'hE0, 1'b0);

    // Back-to-back with req_valid held; inputs change while busy.
    lat_cfg = 2;
    rd_base = 32'hB0;
    expect_line(1'b1, 26'h41, {32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001, 32'h5A5A0000},
                2, 32'h0, 1'b0);
    expect_line(1'b0, 26'h84, 128'h0, 2, 32'hB0, 1'b0);
    a0 = n_acc;
    r0 = n_resp;
    @(posedge clk);
    #2;
    req_valid = 1'b1;
    req_rw    = 1'b1;
    req_addr  = 26'h41;
    req_wdata = {32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001, 32'h5A5A0000};
    wait_acc(a0 + 1);
    req_rw    = 1'b0;
    req_addr  = 26'h84;
    req_wdata = {4{32'hFFFF0000}};
    wait_acc(a0 + 2);
    req_valid = 1'b0;
    wait_resp(r0 + 2);
    chk("t6_b2b_gap", 32'(acc_h[(a0 + 1) % 64] - resp_h[r0 % 64]), 32'd1);
    chk("sb_beats_empty", 32'(beat_q.size()), 32'd0);
    chk("sb_resp_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
